cpu_thread_sched: RTL and testbench

- Round-robin thread scheduler for the multi-threaded CPU core.
- Owns `thread_num` and drives the per-thread context save/restore strobes (`save_en`, `load_en`) into the flags store and other per-thread register files.
- Sequences every context switch as save (outgoing thread), select, then load (incoming thread).
- Switches on an explicit yield (`switch_req`) or on expiry of a time-slice quantum.

---
 rtl/cpu_thread_sched.sv | 144 ++++++++++++++
 tb/tb_cpu_thread_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_thread_sched.sv
// Round-robin hardware thread scheduler: sequences save -> select -> load
// context switches on yield or time-slice expiry and owns thread_num.
module cpu_thread_sched #(
   parameter int N_THREADS     = 4,
   parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
   parameter int QUANTUM       = 16,
   parameter int QUANTUM_MSB   = (QUANTUM < 2) ? 0 : $clog2(QUANTUM + 1) - 1
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic [N_THREADS-1:0]   thread_ready,
   input  logic                   switch_req,
   input  logic                   stall,
   output logic [N_THREADS_MSB:0] thread_num,
   output logic                   save_en,
   output logic                   load_en,
   output logic                   cpu_run,
   output logic [15:0]            switch_cnt
);

   localparam int TW = N_THREADS_MSB + 1;
   localparam int QW = QUANTUM_MSB + 1;
   localparam logic [QW-1:0] Q_LAST = QW'((QUANTUM == 0) ? 0 : QUANTUM - 1);
   localparam logic [N_THREADS-1:0] ONE_T = N_THREADS'(1);
   localparam logic [TW-1:0] LAST_IDX = TW'(N_THREADS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      SAVE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   thread_num_q, thread_num_d;
   logic [TW-1:0]   last_q, last_d;
   logic [QW-1:0]   cnt_q, cnt_d;
   logic [15:0]     switch_cnt_q, switch_cnt_d;
   logic            save_en_q, save_en_d;
   logic            load_en_q, load_en_d;
   logic            cpu_run_q, cpu_run_d;
   logic [N_THREADS-1:0] others;
   logic            q_expire;

   // Rotate so base+1 sits at bit 0; base itself lands last in the scan.
   function automatic logic [TW-1:0] sel(input logic [TW-1:0] base,
                                         input logic [N_THREADS-1:0] mask);
      logic [2*N_THREADS-1:0] rot;
      logic [TW-1:0]          r;
      logic                   hit;
      int                     idx;
      rot = {mask, mask} >> (int'(base) + 1);
      r   = base;
      hit = 1'b0;
      for (int i = 0; i < N_THREADS; i++) begin
         if (!hit && rot[0]) begin
            idx = int'(base) + 1 + i;
            if (idx >= N_THREADS) idx = idx - N_THREADS;
            r   = TW'(idx);
            hit = 1'b1;
         end
         rot = rot >> 1;
      end
      return r;
   endfunction

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= IDLE;
         thread_num_q <= '0;
         last_q       <= LAST_IDX;
         cnt_q        <= '0;
         switch_cnt_q <= '0;
         save_en_q    <= 1'b0;
         load_en_q    <= 1'b0;
         cpu_run_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         thread_num_q <= thread_num_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         switch_cnt_q <= switch_cnt_d;
         save_en_q    <= save_en_d;
         load_en_q    <= load_en_d;
         cpu_run_q    <= cpu_run_d;
      end
   end

   assign others   = thread_ready & ~(ONE_T << thread_num_q);
   assign q_expire = (QUANTUM != 0) && (cnt_q == Q_LAST) && !stall
                     && (|others);

   always_comb begin
      state_d      = state_q;
      thread_num_d = thread_num_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      switch_cnt_d = switch_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|thread_ready) begin
               thread_num_d = sel(last_q, thread_ready);
               state_d      = LOAD;
            end
         end
         LOAD: begin
            state_d      = RUN;
            cnt_d        = '0;
            switch_cnt_d = switch_cnt_q + 16'd1;
         end
         RUN: begin
            if (switch_req || q_expire) begin
               state_d = SAVE;
            end else if (cnt_q != Q_LAST) begin
               cnt_d = cnt_q + QW'(1);
            end
         end
         SAVE: begin
            last_d = thread_num_q;
            if (|thread_ready) begin
               thread_num_d = sel(thread_num_q, thread_ready);
               state_d      = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes are registered decodes of the next state.
   always_comb begin
      save_en_d = (state_d == SAVE);
      load_en_d = (state_d == LOAD);
      cpu_run_d = (state_d == RUN);
   end

   assign thread_num = thread_num_q;
   assign save_en    = save_en_q;
   assign load_en    = load_en_q;
   assign cpu_run    = cpu_run_q;
   assign switch_cnt = switch_cnt_q;

endmodule

// File: tb/tb_cpu_thread_sched.sv
// Bench for cpu_thread_sched: directed scenarios plus random traffic,
// checked every cycle against a slice-level behavioural model.
module tb_cpu_thread_sched;

   localparam int N = 4;
   localparam int Q = 8;

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_RUN  = 2;
   localparam int P_SAVE = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst4_n, sw4, st4;
   logic [3:0]  rdy4;
   logic [1:0]  tn4;
   logic        sv4, ld4, run4;
   logic [15:0] cnt4;

   logic        rst3_n, sw3, st3;
   logic [2:0]  rdy3;
   logic [1:0]  tn3;
   logic        sv3, ld3, run3;
   logic [15:0] cnt3;

   int n_cmp = 0;
   int n_err = 0;

   int          m_ph;
   int          m_cur;
   int          m_age;
   bit          m_fresh;
   logic [15:0] m_sw;

   cpu_thread_sched #(.N_THREADS(N), .QUANTUM(Q)) u_dut4 (
      .CLK(clk), .RESET_N(rst4_n), .thread_ready(rdy4),
      .switch_req(sw4), .stall(st4), .thread_num(tn4),
      .save_en(sv4), .load_en(ld4), .cpu_run(run4),
      .switch_cnt(cnt4)
   );

   cpu_thread_sched #(.N_THREADS(3), .QUANTUM(4)) u_dut3 (
      .CLK(clk), .RESET_N(rst3_n), .thread_ready(rdy3),
      .switch_req(sw3), .stall(st3), .thread_num(tn3),
      .save_en(sv3), .load_en(ld3), .cpu_run(run3),
      .switch_cnt(cnt3)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin pick: first ready thread after base, base itself last.
   function automatic int pick(int base, logic [3:0] m, int n);
      int t;
      for (int k = 1; k <= n; k++) begin
         t = (base + k) % n;
         if (((m >> t) & 4'd1) != 4'd0) return t;
      end
      return base;
   endfunction

   task automatic mreset();
      m_ph    = P_IDLE;
      m_cur   = 0;
      m_age   = 0;
      m_fresh = 1'b1;
      m_sw    = '0;
   endtask

   task automatic mstep();
      logic [3:0] oth;
      oth = rdy4 & ~(4'b0001 << m_cur);
      case (m_ph)
         P_IDLE: if (rdy4 != 4'd0) begin
            m_cur   = pick(m_fresh ? N - 1 : m_cur, rdy4, N);
            m_fresh = 1'b0;
            m_ph    = P_LOAD;
         end
         P_LOAD: begin
            m_ph  = P_RUN;
            m_age = 0;
            m_sw  = m_sw + 16'd1;
         end
         P_RUN: begin
            if (sw4) m_ph = P_SAVE;
            else if (m_age >= Q - 1 && !st4 && oth != 4'd0) m_ph = P_SAVE;
            else m_age++;
         end
         default: begin
            if (rdy4 != 4'd0) begin
               m_cur = pick(m_cur, rdy4, N);
               m_ph  = P_LOAD;
            end else begin
               m_ph = P_IDLE;
            end
         end
      endcase
   endtask

   task automatic cyc();
      @(posedge clk);
      mstep();
      #1;
      chk("m_tn", 32'(tn4), 32'(m_cur));
      chk("m_save", 32'(sv4), 32'(m_ph == P_SAVE));
      chk("m_load", 32'(ld4), 32'(m_ph == P_LOAD));
      chk("m_run", 32'(run4), 32'(m_ph == P_RUN));
      chk("m_cnt", 32'(cnt4), 32'(m_sw));
   endtask

   initial begin
      int n;
      int k;
      rst4_n = 1'b0; rst3_n = 1'b0;
      rdy4 = '0; sw4 = 1'b0; st4 = 1'b0;
      rdy3 = '0; sw3 = 1'b0; st3 = 1'b0;
      mreset();
      #2;
      chk("rst_tn", 32'(tn4), 0);
      chk("rst_save", 32'(sv4), 0);
      chk("rst_load", 32'(ld4), 0);
      chk("rst_run", 32'(run4), 0);
      chk("rst_cnt", 32'(cnt4), 0);
      @(negedge clk);
      rst4_n = 1'b1;

      // Leave IDLE: thread 0 is picked first.
      rdy4 = 4'b0101;
      cyc();
      chk("idle_load", 32'(ld4), 1);
      chk("idle_tn", 32'(tn4), 0);
      cyc();
      chk("idle_run", 32'(run4), 1);
      chk("idle_cnt", 32'(cnt4), 1);

      // Yield: save 0, load 2, run, 3 cycles total.
      rdy4 = 4'b1101; sw4 = 1'b1;
      cyc();
      chk("yld_save", 32'(sv4), 1);
      chk("yld_save_tn", 32'(tn4), 0);
      sw4 = 1'b0;
      cyc();
      chk("yld_load", 32'(ld4), 1);
      chk("yld_load_tn", 32'(tn4), 2);
      cyc();
      chk("yld_run", 32'(run4), 1);
      chk("yld_cnt", 32'(cnt4), 2);

      // Quantum preemption between threads 0 and 1.
      rdy4 = 4'b0011;
      for (int s = 0; s < 4; s++) begin
         k = 0;
         while (ld4 !== 1'b1 && k < 30) begin
            cyc();
            k++;
         end
         chk("slice_wait", 32'(ld4), 1);
         chk("slice_tn", 32'(tn4), 32'(s % 2));
         n = 0;
         cyc();
         while (run4 === 1'b1 && n < 20) begin
            n++;
            cyc();
         end
         chk("slice_len", 32'(n), 8);
      end

      // Stall holds off preemption well past expiry.
      k = 0;
      while (ld4 !== 1'b1 && k < 10) begin
         cyc();
         k++;
      end
      chk("stall_wait", 32'(ld4), 1);
      st4 = 1'b1;
      for (int i = 0; i < 13; i++) begin
         cyc();
         chk("stall_run", 32'(run4), 1);
         chk("stall_nosave", 32'(sv4), 0);
      end
      st4 = 1'b0;
      cyc();
      chk("stall_save", 32'(sv4), 1);
      chk("stall_save_tn", 32'(tn4), 0);

      // Sole ready thread reselects itself, then drop to IDLE.
      rdy4 = 4'b0001;
      cyc();
      chk("self_load0", 32'(tn4), 0);
      cyc();
      sw4 = 1'b1;
      cyc();
      chk("self_save", 32'(sv4), 1);
      sw4 = 1'b0;
      cyc();
      chk("self_load", 32'(ld4), 1);
      chk("self_tn", 32'(tn4), 0);
      cyc();
      sw4 = 1'b1; rdy4 = 4'b0000;
      cyc();
      chk("drop_save", 32'(sv4), 1);
      sw4 = 1'b0;
      cyc();
      chk("drop_run", 32'(run4), 0);
      chk("drop_tn", 32'(tn4), 0);
      cyc();
      chk("drop_load", 32'(ld4), 0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rdy4 = 4'($urandom);
         if ($urandom_range(0, 9) == 0) rdy4 = 4'b0000;
         sw4 = ($urandom_range(0, 7) == 0);
         st4 = ($urandom_range(0, 3) == 0);
         cyc();
      end
      rdy4 = 4'b0000; sw4 = 1'b0; st4 = 1'b0;

      // Three threads: wrap 2 -> 0, then reset inside SAVE.
      rst3_n = 1'b1;
      rdy3 = 3'b111;
      cyc();
      chk("n3_load0", 32'(ld3), 1);
      chk("n3_tn0", 32'(tn3), 0);
      for (int t = 1; t <= 3; t++) begin
         cyc();
         chk("n3_run", 32'(run3), 1);
         sw3 = 1'b1;
         cyc();
         chk("n3_save", 32'(sv3), 1);
         sw3 = 1'b0;
         cyc();
         chk("n3_load", 32'(ld3), 1);
         chk("n3_tn", 32'(tn3), 32'(t % 3));
      end
      cyc();
      sw3 = 1'b1;
      cyc();
      chk("n3_save_rst", 32'(sv3), 1);
      #1 rst3_n = 1'b0;
      #1;
      chk("arst_save", 32'(sv3), 0);
      chk("arst_load", 32'(ld3), 0);
      chk("arst_run", 32'(run3), 0);
      chk("arst_tn", 32'(tn3), 0);
      chk("arst_cnt", 32'(cnt3), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
